// File: rtl/execute_stage_pkg.sv
// Shared opcode encodings and default width for the LEGv8 execute stage.
// Optional NZCV flag output is enabled with the EXECUTE_FLAGS_EN macro.
package execute_stage_pkg;

  localparam int DATA_W_DEF = 64;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational LEGv8 ALU; undefined opcodes yield a zero result.
// With EXECUTE_FLAGS_EN defined it also produces {N, Z, C, V}.
module alu
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        AluControl,
  output logic [DATA_W-1:0] result,
`ifdef EXECUTE_FLAGS_EN
  output logic [3:0]        flags,
`endif
  output logic              zero
);

  logic [DATA_W-1:0] add_res;
  logic [DATA_W-1:0] sub_res;

`ifdef EXECUTE_FLAGS_EN
  // Subtract is formed as A + ~B + 1 so its carry is the NOT-borrow.
  logic [DATA_W:0] sum_w;
  logic [DATA_W:0] diff_w;
  logic            carry;
  logic            ovf;

  assign sum_w   = {1'b0, a} + {1'b0, b};
  assign diff_w  = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
  assign add_res = sum_w[DATA_W-1:0];
  assign sub_res = diff_w[DATA_W-1:0];
`else
  assign add_res = a + b;
  assign sub_res = a - b;
`endif

  always_comb begin
    result = '0;
    unique case (AluControl)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD:   result = add_res;
      ALU_SUB:   result = sub_res;
      ALU_PASSB: result = b;
      ALU_NOR:   result = ~(a | b);
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

`ifdef EXECUTE_FLAGS_EN
  always_comb begin
    carry = 1'b0;
    ovf   = 1'b0;
    if (AluControl == ALU_ADD) begin
      carry = sum_w[DATA_W];
      ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (add_res[DATA_W-1] != a[DATA_W-1]);
    end else if (AluControl == ALU_SUB) begin
      carry = diff_w[DATA_W];
      ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (sub_res[DATA_W-1] != a[DATA_W-1]);
    end
  end

  assign flags = {result[DATA_W-1], zero, carry, ovf};
`endif

endmodule

// File: rtl/execute_stage.sv
// LEGv8 EX stage: operand-B mux, ALU, branch-target adder and EX/MEM register.
// Defining EXECUTE_FLAGS_EN adds the registered flags_E[3:0] = {N, Z, C, V} port.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              AluSrc,
  input  logic [3:0]        AluControl,
  input  logic [DATA_W-1:0] PC_E,
  input  logic [DATA_W-1:0] signImm_E,
  input  logic [DATA_W-1:0] readData1_E,
  input  logic [DATA_W-1:0] readData2_E,
  output logic [DATA_W-1:0] PCBranch_E,
  output logic [DATA_W-1:0] aluResult_E,
  output logic [DATA_W-1:0] writeData_E,
`ifdef EXECUTE_FLAGS_EN
  output logic [3:0]        flags_E,
`endif
  output logic              zero_E
);

  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic [DATA_W-1:0] pc_branch_d, pc_branch_q;
  logic [DATA_W-1:0] alu_result_d, alu_result_q;
  logic [DATA_W-1:0] write_data_d, write_data_q;
  logic              zero_d, zero_q;
`ifdef EXECUTE_FLAGS_EN
  logic [3:0]        alu_flags;
  logic [3:0]        flags_d, flags_q;
`endif

  assign operand_b = AluSrc ? signImm_E : readData2_E;

  alu #(.DATA_W(DATA_W)) u_alu (
    .a          (readData1_E),
    .b          (operand_b),
    .AluControl (AluControl),
    .result     (alu_result),
`ifdef EXECUTE_FLAGS_EN
    .flags      (alu_flags),
`endif
    .zero       (alu_zero)
  );

  // Word offset: the two bits shifted out of the immediate are simply dropped.
  assign pc_branch_d  = PC_E + {signImm_E[DATA_W-3:0], 2'b00};
  assign alu_result_d = alu_result;
  assign write_data_d = readData2_E;
  assign zero_d       = alu_zero;
`ifdef EXECUTE_FLAGS_EN
  assign flags_d      = alu_flags;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_branch_q  <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      zero_q       <= 1'b0;
`ifdef EXECUTE_FLAGS_EN
      flags_q      <= '0;
`endif
    end else begin
      pc_branch_q  <= pc_branch_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      zero_q       <= zero_d;
`ifdef EXECUTE_FLAGS_EN
      flags_q      <= flags_d;
`endif
    end
  end

  assign PCBranch_E  = pc_branch_q;
  assign aluResult_E = alu_result_q;
  assign writeData_E = write_data_q;
  assign zero_E      = zero_q;
`ifdef EXECUTE_FLAGS_EN
  assign flags_E     = flags_q;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed literal cases plus random
// stimulus compared every cycle against an arithmetic reference model.
module tb_execute_stage;

  localparam int DW = 64;

  typedef struct {
    logic [DW-1:0] res;
    logic          zero;
    logic [DW-1:0] pcb;
    logic [DW-1:0] wd;
    logic [3:0]    flags;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic          AluSrc;
  logic [3:0]    AluControl;
  logic [DW-1:0] PC_E, signImm_E, readData1_E, readData2_E;
  logic [DW-1:0] PCBranch_E, aluResult_E, writeData_E;
  logic          zero_E;
`ifdef EXECUTE_FLAGS_EN
  logic [3:0]    flags_E;
`endif

  int total = 0;
  int bad   = 0;

  exp_t exp_q = '{res: '0, zero: 1'b0, pcb: '0, wd: '0, flags: 4'h0};
  bit   cmp_en = 0;

  execute_stage #(.DATA_W(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .AluSrc      (AluSrc),
    .AluControl  (AluControl),
    .PC_E        (PC_E),
    .signImm_E   (signImm_E),
    .readData1_E (readData1_E),
    .readData2_E (readData2_E),
    .PCBranch_E  (PCBranch_E),
    .aluResult_E (aluResult_E),
    .writeData_E (writeData_E),
`ifdef EXECUTE_FLAGS_EN
    .flags_E     (flags_E),
`endif
    .zero_E      (zero_E)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference: outputs computed straight from the opcode table with wide arithmetic.
  function automatic exp_t model(input logic src, input logic [3:0] op,
                                 input logic [DW-1:0] pc, input logic [DW-1:0] imm,
                                 input logic [DW-1:0] r1, input logic [DW-1:0] r2);
    exp_t e;
    logic [DW-1:0] b;
    logic [DW:0]   wide;
    logic signed [DW+1:0] sw;
    logic c, v;
    b = src ? imm : r2;
    c = 0;
    v = 0;
    case (op)
      4'b0000: e.res = r1 & b;
      4'b0001: e.res = r1 | b;
      4'b0010: begin
        wide  = {1'b0, r1} + {1'b0, b};
        e.res = wide[DW-1:0];
        c     = wide[DW];
        sw    = $signed({r1[DW-1], r1[DW-1], r1}) + $signed({b[DW-1], b[DW-1], b});
        v     = (sw > $signed({2'b00, 1'b0, {(DW-1){1'b1}}})) ||
                (sw < -$signed({2'b00, 1'b1, {(DW-1){1'b0}}}));
      end
      4'b0110: begin
        e.res = r1 - b;
        c     = (r1 >= b);
        sw    = $signed({r1[DW-1], r1[DW-1], r1}) - $signed({b[DW-1], b[DW-1], b});
        v     = (sw > $signed({2'b00, 1'b0, {(DW-1){1'b1}}})) ||
                (sw < -$signed({2'b00, 1'b1, {(DW-1){1'b0}}}));
      end
      4'b0111: e.res = b;
      4'b1100: e.res = ~(r1 | b);
      default: e.res = '0;
    endcase
    e.zero  = (e.res == 0);
    e.pcb   = pc + imm * 4;
    e.wd    = r2;
    e.flags = {e.res[DW-1], e.zero, c, v};
    return e;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      exp_q <= '{res: '0, zero: 1'b0, pcb: '0, wd: '0, flags: 4'h0};
    else
      exp_q <= model(AluSrc, AluControl, PC_E, signImm_E, readData1_E, readData2_E);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model aluResult", aluResult_E, exp_q.res);
      chk("model zero", {63'd0, zero_E}, {63'd0, exp_q.zero});
      chk("model PCBranch", PCBranch_E, exp_q.pcb);
      chk("model writeData", writeData_E, exp_q.wd);
`ifdef EXECUTE_FLAGS_EN
      chk("model flags", {60'd0, flags_E}, {60'd0, exp_q.flags});
`endif
    end
  end

  task automatic drive(input logic src, input logic [3:0] op, input logic [DW-1:0] pc,
                       input logic [DW-1:0] imm, input logic [DW-1:0] r1, input logic [DW-1:0] r2);
    AluSrc      = src;
    AluControl  = op;
    PC_E        = pc;
    signImm_E   = imm;
    readData1_E = r1;
    readData2_E = r2;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [DW-1:0] res, input logic z);
    chk({name, " result"}, aluResult_E, res);
    chk({name, " zero"}, {63'd0, zero_E}, {63'd0, z});
  endtask

  initial begin
    logic [3:0]    ops [8];
    logic [DW-1:0] r1, r2, imm;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b0011};

    reset_n = 0;
    drive(1'b1, 4'b0010, {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom}, {$urandom, $urandom});
    repeat (3) @(negedge clk);
    cmp_en = 1;
    lit("reset", 64'h0, 1'b0);
    chk("reset PCBranch", PCBranch_E, 64'h0);
    chk("reset writeData", writeData_E, 64'h0);

    drive(1'b0, 4'b0010, 64'h4, 64'h8, 64'h2, 64'h3);
    reset_n = 1;
    step;
    lit("add reg", 64'h5, 1'b0);
    chk("add PCBranch", PCBranch_E, 64'h24);
    chk("add writeData", writeData_E, 64'h3);
    @(negedge clk);
    AluSrc = 1;
    step;
    lit("add imm", 64'hA, 1'b0);
    chk("add imm writeData", writeData_E, 64'h3);

    @(negedge clk);
    drive(1'b0, 4'b0000, 64'h10, 64'h4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_FFFF);
    step;
    lit("and", 64'hFFFF, 1'b0);
    chk("branch +4", PCBranch_E, 64'h20);

    @(negedge clk);
    drive(1'b0, 4'b0110, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA, 64'hA);
    step;
    lit("sub equal", 64'h0, 1'b1);
    chk("branch -1", PCBranch_E, 64'hC);

    @(negedge clk);
    drive(1'b0, 4'b0110, 64'h0, 64'h0, 64'h0, 64'h1);
    step;
    lit("sub wrap", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    @(negedge clk);
    drive(1'b0, 4'b0001, 64'h0, 64'h0, 64'hF0, 64'h0F);
    step;
    lit("or", 64'hFF, 1'b0);
    @(negedge clk);
    AluControl = 4'b1100;
    step;
    lit("nor", 64'hFFFF_FFFF_FFFF_FF00, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'b0111, 64'h8, 64'h1, 64'h5, 64'h0);
    step;
    lit("passb zero", 64'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'b1111, 64'h8, 64'h1, 64'h5, 64'h7);
    step;
    lit("undefined", 64'h0, 1'b1);

    @(negedge clk);
    drive(1'b0, 4'b0010, 64'h100, 64'h3, 64'h1, 64'h1);
    step;
    #1 reset_n = 0;
    #1;
    lit("async reset", 64'h0, 1'b0);
    chk("async reset PCBranch", PCBranch_E, 64'h0);
    chk("async reset writeData", writeData_E, 64'h0);
    #1 reset_n = 1;

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      r1  = {$urandom, $urandom};
      r2  = ($urandom_range(0, 3) == 0) ? r1 : {$urandom, $urandom};
      imm = ($urandom_range(0, 3) == 0) ? 64'(-$signed(64'($urandom_range(0, 64))))
                                        : {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) r2 = 64'h0;
      drive(1'($urandom_range(0, 1)), ops[$urandom_range(0, 7)], {$urandom, $urandom},
            imm, r1, r2);
      if (i % 97 == 50) begin
        #2 reset_n = 0;
        #1 reset_n = 1;
      end
    end
    @(negedge clk);
    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
